// File: rtl/ifetch_queue.sv
// Purpose: dual-issue fetch stage that owns the fetch PC and buffers {pc,instr} pairs for decode.
// Latency: a word fetched in cycle N is presented on out_* in cycle N+1; up to 2 instr/cycle each way.
// Backpressure: decode requests via deq_count (clamped to occupancy); fetch throttles on queue space and end of ROM.
module ifetch_queue #(
    parameter int          DEPTH      = 4,
    parameter int          IMEM_WORDS = 16,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr0,
    output logic [31:0] imem_addr1,
    input  logic [31:0] imem_rdata0,
    input  logic [31:0] imem_rdata1,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  deq_count,
    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_instr0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_instr1,
    output logic [31:0] fetch_pc,
    output logic        halted
);

    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW       = PW + 1;
    localparam logic [31:0] END_ADDR = 32'(IMEM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   pc_r;

    logic [PW-1:0] head1;
    logic [PW-1:0] tail1;
    logic [CW-1:0] deq_n;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] free;
    logic [31:0]   words_left;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign fetch_pc   = pc_r;
    assign imem_addr0 = pc_r;
    assign imem_addr1 = pc_r + 32'd4;
    assign halted     = (pc_r >= END_ADDR);

    assign head1      = head + PW'(1);
    assign tail1      = tail + PW'(1);
    assign out_valid  = {(count >= CW'(2)), (count >= CW'(1))};
    assign out_pc0    = pc_mem[head];
    assign out_instr0 = instr_mem[head];
    assign out_pc1    = pc_mem[head1];
    assign out_instr1 = instr_mem[head1];

    // Free space uses start-of-cycle occupancy: slots vacated by this cycle's dequeue are not reused until next cycle.
    always_comb begin
        deq_n      = CW'(deq_count);
        free       = DEPTH_C - count;
        words_left = halted ? 32'd0 : ((END_ADDR - pc_r) >> 2);
        enq_n      = CW'(2);
        if (deq_n > count) begin
            deq_n = count;
        end
        if (free < enq_n) begin
            enq_n = free;
        end
        if (words_left < 32'(enq_n)) begin
            enq_n = CW'(words_left);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= 32'd0;
                instr_mem[i] <= 32'd0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc_r  <= RESET_PC;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc_r  <= {redirect_pc[31:2], 2'b00};
        end else begin
            if (enq_n != '0) begin
                pc_mem[tail]    <= pc_r;
                instr_mem[tail] <= imem_rdata0;
            end
            // At END-4 only one word is left, so slot 1 (and imem_rdata1) is dropped.
            if (enq_n == CW'(2)) begin
                pc_mem[tail1]    <= pc_r + 32'd4;
                instr_mem[tail1] <= imem_rdata1;
            end
            tail  <= tail + PW'(enq_n);
            head  <= head + PW'(deq_n);
            count <= count + enq_n - deq_n;
            pc_r  <= pc_r + (32'(enq_n) << 2);
        end
    end

endmodule
